frog_controller: RTL and testbench
==================================

Name: frog_controller

Overview:
- Player-input and game-state stage that sits directly upstream of the pixel renderer, alongside the lane/car logic.
- Debounces the four direction buttons and moves the frog on a cell grid.
- Consumes a collision flag from the renderer and tracks lives, score and game state.
- Drives the frog position in pixel coordinates to the renderer, for drawing against CounterX/CounterY.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a debounced level changes (set about 1,000,000 for synthesis).
- GRID_COLS, 10, number of columns; each cell is 64 px wide (max 16).
- GRID_ROWS, 8, number of rows; each cell is 60 px tall (max 8). Row 0 is the goal at the top; row GRID_ROWS-1 is the start row.
- START_COL, 5, spawn column.
- LIVES, 3, lives at game start (1..3).
- DEATH_HOLD, 8, cycles spent in DEAD before respawn or game over.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- btn_up  in  1  raw button, active high, asynchronous to clk
- btn_down  in  1  raw button, active high
- btn_left  in  1  raw button, active high
- btn_right  in  1  raw button, active high
- hit  in  1  frog/car overlap flag from the renderer, synchronous to clk
- frog_col  out  4  current column
- frog_row  out  3  current row
- frog_x  out  10  frog_col*64, left pixel edge
- frog_y  out  9  frog_row*60, top pixel edge
- lives  out  2  remaining lives
- score  out  8  successful crossings
- state  out  2  0=IDLE, 1=PLAY, 2=DEAD, 3=OVER
- died  out  1  one-cycle pulse on life loss
- won  out  1  one-cycle pulse on crossing

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, frog_col=START_COL, frog_row=GRID_ROWS-1, lives=LIVES, score=0.
  - died=0, won=0; all synchronizers, debounce counters and debounced levels cleared.
  - Reset mid-game aborts everything immediately, with no pulses.
- Input conditioning, per button:
  - 2-flop synchronizer, then a counter.
  - The counter clears whenever the synced input equals the debounced level.
  - Once the synced input has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips.
  - press = one-cycle pulse in the cycle the debounced level goes 0->1. No auto-repeat.
- Latency: a clean button rise reaches frog_col/frog_row on the edge after the press pulse, i.e. 2+DEBOUNCE_CYCLES+1 clk edges after first being sampled high. frog_x/frog_y update on that same edge.
- Priority when several presses coincide: up > down > left > right. Only one move is applied.
- IDLE:
  - hit is ignored.
  - Any press -> PLAY. That press does not move the frog.
- PLAY:
  - up: frog_row-1. Down: frog_row+1, saturating at GRID_ROWS-1. Left/right: frog_col∓1, saturating at 0 and GRID_COLS-1.
  - An up move from row 1 is a crossing:
    - the frog is placed at START_COL, GRID_ROWS-1;
    - score+1, saturating at 255;
    - won=1 for the next cycle;
    - state stays PLAY.
  - hit=1 in any PLAY cycle:
    - lives-1;
    - died=1 for the next cycle;
    - state -> DEAD; position frozen.
  - hit and press in the same cycle: hit wins and the move is discarded.
- DEAD:
  - Counts DEATH_HOLD cycles; hit and presses are ignored.
  - At expiry: if lives==0 -> OVER.
  - Otherwise respawn at START_COL, GRID_ROWS-1 and -> PLAY.
- OVER:
  - Position, score and lives hold; hit is ignored.
  - Any press -> IDLE, with lives=LIVES, score=0 and position at spawn.
- Arithmetic:
  - frog_x = {frog_col,6'b0}.
  - frog_y = frog_row*60, computed as (row<<6)-(row<<2) in 9 bits; max 420.
- died and won are never asserted together.

Optional Feature:
- Macro: FROG_WRAP_EN.
- When defined: left at col 0 -> GRID_COLS-1, and right at GRID_COLS-1 -> 0.
- When undefined: left/right saturate as described above.
- Vertical movement is unaffected either way.

Test Plan:
- Reset, then hold btn_up high 20 cycles (DEBOUNCE_CYCLES=4) -> state IDLE->PLAY on the edge after the press pulse; frog_row stays 7, frog_y=420.
- In PLAY, 8 bounce toggles of width 1-3 cycles on btn_left, then a clean press -> exactly one move: frog_col 5->4, frog_x=256.
- In PLAY, press up 7 times -> frog_row 7..1; the 7th press gives won=1 for 1 cycle, score=1, frog_row=7, frog_col=5.
- In PLAY, hit=1 and a right press in the same cycle -> died pulse, lives 3->2, state=DEAD, column unchanged; after 8 cycles state=PLAY at spawn.
- Three hits in total -> state OVER with lives=0; a later press -> IDLE, lives=3, score=0.
- Press right 6 times from col 5 -> col saturates at 9 without FROG_WRAP_EN; with FROG_WRAP_EN the 5th press gives col 0.

Source files
------------

// File: rtl/frog_controller.sv
// rtl/frog_controller.sv - frog button debounce, grid movement, lives/score game FSM (wrap option: FROG_WRAP_EN)
module frog_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GRID_COLS       = 10,
  parameter int GRID_ROWS       = 8,
  parameter int START_COL       = 5,
  parameter int LIVES           = 3,
  parameter int DEATH_HOLD      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  output logic [3:0] frog_col,
  output logic [2:0] frog_row,
  output logic [9:0] frog_x,
  output logic [8:0] frog_y,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [1:0] state,
  output logic       died,
  output logic       won
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DEATH_HOLD - 1);
  localparam logic [3:0]    COL_MAX   = 4'(GRID_COLS - 1);
  localparam logic [3:0]    COL_START = 4'(START_COL);
  localparam logic [2:0]    ROW_START = 3'(GRID_ROWS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
`ifdef FROG_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2, OVER = 2'd3} state_t;

  state_t          state_q;
  logic [3:0]      raw, sync1, sync2, deb, press;
  logic [CW-1:0]   cnt [4];
  logic [HW-1:0]   hold_cnt;
  logic            any_press;

  // bit 0 = up ... bit 3 = right, so lower index means higher move priority
  assign raw       = {btn_right, btn_left, btn_down, btn_up};
  assign any_press = |press;
  assign state     = state_q;
  assign frog_x    = {frog_col, 6'b0};
  assign frog_y    = {frog_row, 6'b0} - {4'b0, frog_row, 2'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i]   <= '0;
          deb[i]   <= ~deb[i];
          press[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      frog_col <= COL_START;
      frog_row <= ROW_START;
      lives    <= LIVES_INIT;
      score    <= '0;
      died     <= 1'b0;
      won      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      died <= 1'b0;
      won  <= 1'b0;
      case (state_q)
        IDLE: if (any_press) state_q <= PLAY;
        PLAY: begin
          if (hit) begin
            lives    <= lives - 1'b1;
            died     <= 1'b1;
            hold_cnt <= '0;
            state_q  <= DEAD;
          end else if (press[0]) begin
            if (frog_row <= 3'd1) begin
              frog_col <= COL_START;
              frog_row <= ROW_START;
              won      <= 1'b1;
              if (score != 8'hFF) score <= score + 1'b1;
            end else begin
              frog_row <= frog_row - 1'b1;
            end
          end else if (press[1]) begin
            if (frog_row != ROW_START) frog_row <= frog_row + 1'b1;
          end else if (press[2]) begin
            if (frog_col != 4'd0) frog_col <= frog_col - 1'b1;
            else if (WRAP)        frog_col <= COL_MAX;
          end else if (press[3]) begin
            if (frog_col != COL_MAX) frog_col <= frog_col + 1'b1;
            else if (WRAP)           frog_col <= 4'd0;
          end
        end
        DEAD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (lives == 2'd0) begin
              state_q <= OVER;
            end else begin
              frog_col <= COL_START;
              frog_row <= ROW_START;
              state_q  <= PLAY;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        OVER: begin
          if (any_press) begin
            state_q  <= IDLE;
            lives    <= LIVES_INIT;
            score    <= '0;
            frog_col <= COL_START;
            frog_row <= ROW_START;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_controller.sv
// tb/tb_frog_controller.sv - directed scoreboard bench for frog_controller
module tb_frog_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       hit;
  logic [3:0] frog_col;
  logic [2:0] frog_row;
  logic [9:0] frog_x;
  logic [8:0] frog_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic [1:0] state;
  logic       died;
  logic       won;

  frog_controller dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .hit(hit), .frog_col(frog_col), .frog_row(frog_row), .frog_x(frog_x), .frog_y(frog_y),
    .lives(lives), .score(score), .state(state), .died(died), .won(won)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   lat, won_cnt, died_cnt, dcyc;
  logic died_next;

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "state":   return 32'(state);
      "col":     return 32'(frog_col);
      "row":     return 32'(frog_row);
      "x":       return 32'(frog_x);
      "y":       return 32'(frog_y);
      "lives":   return 32'(lives);
      "score":   return 32'(score);
      "died":    return 32'(died);
      "won":     return 32'(won);
      "lat":     return 32'(lat);
      "won_cnt": return 32'(won_cnt);
      "died_nx": return 32'(died_next);
      "dcyc":    return 32'(dcyc);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int value);
    exp_t e;
    e.tag = tag;
    e.exp = 32'(value);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.tag);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic press(input int b);
    won_cnt  = 0;
    died_cnt = 0;
    btn[b] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      won_cnt  += int'(won);
      died_cnt += int'(died);
    end
    btn[b] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      won_cnt  += int'(won);
      died_cnt += int'(died);
    end
  endtask

  task automatic hit_once();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  int bounce_w[8] = '{1, 2, 3, 1, 3, 2, 2, 1};
`ifdef FROG_WRAP_EN
  int right_exp[6] = '{6, 7, 8, 9, 0, 1};
`else
  int right_exp[6] = '{6, 7, 8, 9, 9, 9};
`endif

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    hit   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_val("state", 0); expect_val("col", 5); expect_val("row", 7);
    expect_val("x", 320);   expect_val("y", 420); expect_val("lives", 3);
    expect_val("score", 0); expect_val("died", 0); expect_val("won", 0);
    drain();

    // hit in IDLE is ignored
    hit_once();
    expect_val("state", 0); expect_val("died", 0);
    drain();

    // IDLE -> PLAY on the edge after the press pulse; press does not move
    btn[0] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (state != 2'd1 && lat < 30);
    expect_val("lat", 7); expect_val("state", 1); expect_val("row", 7); expect_val("y", 420);
    drain();
    repeat (13) @(negedge clk);
    btn[0] = 1'b0;
    repeat (10) @(negedge clk);
    expect_val("row", 7); expect_val("col", 5);
    drain();

    // bounces shorter than the debounce window never move the frog
    foreach (bounce_w[i]) begin
      btn[2] = ~btn[2];
      repeat (bounce_w[i]) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    expect_val("col", 5);
    drain();
    press(2);
    expect_val("col", 4); expect_val("x", 256);
    drain();

    // climb to the goal
    for (int k = 1; k <= 7; k++) begin
      press(0);
      if (k < 7) begin
        expect_val("row", 7 - k); expect_val("y", (7 - k) * 60); expect_val("won_cnt", 0);
      end else begin
        expect_val("won_cnt", 1); expect_val("score", 1);
        expect_val("row", 7); expect_val("col", 5);
      end
      drain();
    end

    // hit and right press land in the same cycle: hit wins
    press(2);
    expect_val("col", 4);
    drain();
    btn[3] = 1'b1;
    repeat (6) @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit    = 1'b0;
    btn[3] = 1'b0;
    expect_val("died", 1); expect_val("won", 0); expect_val("state", 2);
    expect_val("lives", 2); expect_val("col", 4);
    drain();
    dcyc = 1;
    @(negedge clk);
    died_next = died;
    if (state == 2'd2) dcyc++;
    while (state == 2'd2 && dcyc < 40) begin
      @(negedge clk);
      if (state == 2'd2) dcyc++;
    end
    expect_val("died_nx", 0); expect_val("dcyc", 8); expect_val("state", 1);
    expect_val("col", 5); expect_val("row", 7); expect_val("lives", 2);
    drain();
    repeat (10) @(negedge clk);

    // remaining lives run out
    hit_once();
    expect_val("died", 1); expect_val("lives", 1);
    drain();
    repeat (10) @(negedge clk);
    expect_val("state", 1);
    drain();
    hit_once();
    expect_val("died", 1); expect_val("lives", 0);
    drain();
    repeat (10) @(negedge clk);
    expect_val("state", 3); expect_val("lives", 0); expect_val("score", 1);
    drain();
    hit_once();
    expect_val("died", 0); expect_val("state", 3);
    drain();
    press(1);
    expect_val("state", 0); expect_val("lives", 3); expect_val("score", 0);
    expect_val("col", 5); expect_val("row", 7);
    drain();

    // back to play: down saturates at the start row, right saturates or wraps
    press(0);
    expect_val("state", 1);
    drain();
    press(1);
    expect_val("row", 7);
    drain();
    for (int k = 0; k < 6; k++) begin
      press(3);
      expect_val("col", right_exp[k]); expect_val("x", right_exp[k] * 64);
      drain();
    end

    // reset together with a hit aborts without a died pulse
    hit   = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    hit   = 1'b0;
    rst_n = 1'b1;
    expect_val("died", 0); expect_val("state", 0); expect_val("col", 5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
